// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port among N_REQ requesters.
// Each granted access runs IDLE -> ACCESS -> RESP, with a bounds check and registered read data.
module data_mem_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 16,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 1000
) (
   input  logic                       clock,
   input  logic                       reset_n,
   input  logic [N_REQ-1:0]           req_valid,
   input  logic [N_REQ-1:0]           req_write,
   input  logic [N_REQ*ADDR_W-1:0]    req_addr,
   input  logic [N_REQ*DATA_W-1:0]    req_wdata,
   output logic [N_REQ-1:0]           req_ready,
   output logic [N_REQ-1:0]           resp_valid,
   output logic [DATA_W-1:0]          resp_rdata,
   output logic                       resp_err,
   output logic [ADDR_W-3:0]          mem_addr,
   output logic [DATA_W-1:0]          mem_wdata,
   output logic                       mem_we,
   output logic                       mem_oe,
   input  logic [DATA_W-1:0]          mem_rdata
);

   localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IDX_W = ADDR_W - 2;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0]    gnt_id_q, gnt_id_d;
   logic                write_q, write_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                err_q, err_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic                win_found_s;
   logic [PTR_W-1:0]    win_id_s;
   logic [PTR_W-1:0]    cand_s;
   logic                win_write_s;
   logic [ADDR_W-1:0]   win_addr_s;
   logic [DATA_W-1:0]   win_wdata_s;
   logic                unused_s;

   // Byte-offset bits never reach the word-addressed memory.
   assign unused_s = ^win_addr_s[1:0];

   // Round-robin scan starting at rr_ptr_q: first valid requester wins.
   always_comb begin
      win_found_s = 1'b0;
      win_id_s    = {PTR_W{1'b0}};
      cand_s      = {PTR_W{1'b0}};
      for (int k = 0; k < N_REQ; k++) begin
         cand_s = PTR_W'((int'(rr_ptr_q) + k) % N_REQ);
         if (!win_found_s && req_valid[cand_s]) begin
            win_found_s = 1'b1;
            win_id_s    = cand_s;
         end else begin
            win_found_s = win_found_s;
         end
      end
   end

   // Multiplex the winning requester's fields.
   always_comb begin
      win_write_s = 1'b0;
      win_addr_s  = {ADDR_W{1'b0}};
      win_wdata_s = {DATA_W{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         if (PTR_W'(i) == win_id_s) begin
            win_write_s = req_write[i];
            win_addr_s  = req_addr[i*ADDR_W +: ADDR_W];
            win_wdata_s = req_wdata[i*DATA_W +: DATA_W];
         end else begin
            win_write_s = win_write_s;
         end
      end
   end

   // Next-state logic: latch the winner on handshake, capture read data in ACCESS.
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      gnt_id_d = gnt_id_q;
      write_d  = write_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      err_d    = err_q;
      rdata_d  = rdata_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s) begin
               state_d  = ST_ACCESS;
               rr_ptr_d = (win_id_s == PTR_W'(N_REQ - 1)) ? {PTR_W{1'b0}} : win_id_s + PTR_W'(1);
               gnt_id_d = win_id_s;
               write_d  = win_write_s;
               idx_d    = win_addr_s[ADDR_W-1:2];
               wdata_d  = win_wdata_s;
               err_d    = (win_addr_s[ADDR_W-1:2] >= IDX_W'(DEPTH));
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            state_d = ST_RESP;
            rdata_d = (!write_q && !err_q) ? mem_rdata : {DATA_W{1'b0}};
         end
         ST_RESP: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and transaction registers; reset aborts any transaction in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= {PTR_W{1'b0}};
         gnt_id_q <= {PTR_W{1'b0}};
         write_q  <= 1'b0;
         idx_q    <= {IDX_W{1'b0}};
         wdata_q  <= {DATA_W{1'b0}};
         err_q    <= 1'b0;
         rdata_q  <= {DATA_W{1'b0}};
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         gnt_id_q <= gnt_id_d;
         write_q  <= write_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         err_q    <= err_d;
         rdata_q  <= rdata_d;
      end
   end

   // Output decode; req_ready is gated by reset_n so every output is 0 while in reset.
   always_comb begin
      req_ready  = {N_REQ{1'b0}};
      resp_valid = {N_REQ{1'b0}};
      resp_rdata = {DATA_W{1'b0}};
      resp_err   = 1'b0;
      mem_addr   = {IDX_W{1'b0}};
      mem_wdata  = {DATA_W{1'b0}};
      mem_we     = 1'b0;
      mem_oe     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (win_found_s && reset_n) begin
               req_ready[win_id_s] = 1'b1;
            end else begin
               req_ready = {N_REQ{1'b0}};
            end
         end
         ST_ACCESS: begin
            mem_addr = idx_q;
            if (err_q) begin
               mem_we = 1'b0;
               mem_oe = 1'b0;
            end else if (write_q) begin
               mem_we    = 1'b1;
               mem_wdata = wdata_q;
            end else begin
               mem_oe = 1'b1;
            end
         end
         ST_RESP: begin
            resp_valid[gnt_id_q] = 1'b1;
            resp_rdata           = write_q ? {DATA_W{1'b0}} : rdata_q;
            resp_err             = err_q;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Scoreboard bench for data_mem_arbiter: expected responses are queued as requests are issued
// and compared against responses logged from the DUT, alongside memory-port and grant observations.
module tb_data_mem_arbiter;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [2:0]    req_valid, req_write, req_ready, resp_valid;
   logic [47:0]   req_addr, req_wdata;
   logic [15:0]   resp_rdata, mem_wdata, mem_rdata;
   logic          resp_err, mem_we, mem_oe;
   logic [13:0]   mem_addr;
   logic [15:0]   mem [0:16383];

   typedef struct packed {logic [2:0] vld; logic [15:0] rdata; logic err; logic [31:0] cyc;} resp_t;
   typedef struct packed {logic [13:0] addr; logic [15:0] data; logic [31:0] cyc;} we_t;
   typedef struct packed {logic [2:0] gnt; logic [31:0] cyc;} hs_t;

   resp_t exp_q[$];
   resp_t resp_obs[$];
   we_t   we_obs[$];
   hs_t   hs_obs[$];
   int    oe_cnt = 0;
   int    cyc = 0;
   int    n_checks = 0;
   int    n_pass = 0;

   data_mem_arbiter dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_oe(mem_oe),
      .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   assign mem_rdata = mem[mem_addr];

   always @(posedge clock) begin
      cyc <= cyc + 1;
      if (mem_we) mem[mem_addr] <= mem_wdata;
   end

   // Observation log, sampled mid-cycle.
   always @(negedge clock) begin
      if (|resp_valid) resp_obs.push_back('{resp_valid, resp_rdata, resp_err, cyc});
      if (mem_we)      we_obs.push_back('{mem_addr, mem_wdata, cyc});
      if (mem_oe)      oe_cnt++;
      if (reset_n && |(req_valid & req_ready)) hs_obs.push_back('{req_valid & req_ready, cyc});
   end

   task automatic clear_logs();
      exp_q.delete(); resp_obs.delete(); we_obs.delete(); hs_obs.delete(); oe_cnt = 0;
   endtask

   task automatic set_req(input int id, input logic w, input logic [15:0] a, input logic [15:0] d);
      req_valid[id] = 1'b1;
      req_write[id] = w;
      req_addr[id*16 +: 16] = a;
      req_wdata[id*16 +: 16] = d;
   endtask

   task automatic push_exp(input logic [2:0] vld, input logic [15:0] rdata, input logic err);
      exp_q.push_back('{vld, rdata, err, 32'd0});
   endtask

   // Wait for n new handshakes; optionally drop each granted requester's valid.
   task automatic run_hs(input int n, input bit drop, output bit ok);
      int start = hs_obs.size();
      int seen  = start;
      ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clock); #1;
         while (seen < hs_obs.size()) begin
            if (drop) req_valid = req_valid & ~hs_obs[seen].gnt;
            seen++;
         end
         if (seen - start >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic wait_resp(input int n, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clock); #1;
         if (resp_obs.size() >= n) begin ok = 1'b1; break; end
      end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      req_valid = 3'b000; req_write = 3'b000; req_addr = 48'd0; req_wdata = 48'd0;
      for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
      mem[1000] = 16'hDEAD;
      set_req(0, 1'b1, 16'h0020, 16'h1111);
      set_req(1, 1'b1, 16'h0020, 16'h2222);
      set_req(2, 1'b1, 16'h0020, 16'h3333);
      repeat (2) @(negedge clock);
      n_checks++;
      if (req_ready !== 3'b000) $display("FAIL reset_req_ready: got %b expected 000", req_ready);
      else n_pass++;
      n_checks++;
      if ({resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_oe} !== 52'd0)
         $display("FAIL reset_outputs: got rv=%b rd=%h re=%b ma=%h mw=%h we=%b oe=%b expected all 0",
                  resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_oe);
      else n_pass++;
   endtask

   task automatic test_rr_order();
      bit ok;
      resp_t got;
      clear_logs();
      push_exp(3'b001, 16'h0000, 1'b0);
      push_exp(3'b010, 16'h0000, 1'b0);
      push_exp(3'b100, 16'h0000, 1'b0);
      @(posedge clock); #1 reset_n = 1'b1;
      run_hs(3, 1'b1, ok);
      n_checks++;
      if (ok !== 1'b1) $display("FAIL rr_handshakes: got %0d grants expected 3", hs_obs.size()); else n_pass++;
      wait_resp(3, ok);
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (hs_obs[i].gnt !== 3'(1 << i)) $display("FAIL rr_grant[%0d]: got %b expected %b", i, hs_obs[i].gnt, 3'(1 << i));
         else n_pass++;
      end
      n_checks++;
      if (we_obs.size() != 3 || we_obs[1].cyc - we_obs[0].cyc != 3 || we_obs[2].cyc - we_obs[1].cyc != 3)
         $display("FAIL rr_we_spacing: got %0d writes expected 3 writes 3 cycles apart", we_obs.size());
      else n_pass++;
      n_checks++;
      if (mem[8] !== 16'h3333) $display("FAIL rr_final_mem: got %h expected 3333", mem[8]); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < resp_obs.size()) ? resp_obs[i] : '0;
         n_checks++;
         if ({got.vld, got.rdata, got.err} !== {exp_q[i].vld, exp_q[i].rdata, exp_q[i].err})
            $display("FAIL rr_resp[%0d]: got %b/%h/%b expected %b/%h/%b", i, got.vld, got.rdata, got.err,
                     exp_q[i].vld, exp_q[i].rdata, exp_q[i].err);
         else n_pass++;
      end
   endtask

   task automatic test_write_read();
      bit ok;
      resp_t got;
      clear_logs();
      set_req(0, 1'b1, 16'h0010, 16'hBEEF);
      push_exp(3'b001, 16'h0000, 1'b0);
      run_hs(1, 1'b1, ok);
      wait_resp(1, ok);
      n_checks++;
      if (we_obs.size() != 1 || we_obs[0].addr !== 14'd4 || we_obs[0].data !== 16'hBEEF)
         $display("FAIL wr_mem_we: got %0d writes addr=%0d data=%h expected 1 write addr=4 data=beef",
                  we_obs.size(), we_obs[0].addr, we_obs[0].data);
      else n_pass++;
      n_checks++;
      if (we_obs[0].cyc - hs_obs[0].cyc != 1) $display("FAIL wr_we_latency: got %0d expected 1", we_obs[0].cyc - hs_obs[0].cyc);
      else n_pass++;
      set_req(0, 1'b0, 16'h0010, 16'h0000);
      push_exp(3'b001, 16'hBEEF, 1'b0);
      run_hs(1, 1'b1, ok);
      wait_resp(2, ok);
      n_checks++;
      if (ok !== 1'b1 || resp_obs[1].cyc - hs_obs[1].cyc != 2)
         $display("FAIL rd_latency: got ok=%0d dist=%0d expected 2", ok, resp_obs[1].cyc - hs_obs[1].cyc);
      else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < resp_obs.size()) ? resp_obs[i] : '0;
         n_checks++;
         if ({got.vld, got.rdata, got.err} !== {exp_q[i].vld, exp_q[i].rdata, exp_q[i].err})
            $display("FAIL wr_rd_resp[%0d]: got %b/%h/%b expected %b/%h/%b", i, got.vld, got.rdata, got.err,
                     exp_q[i].vld, exp_q[i].rdata, exp_q[i].err);
         else n_pass++;
      end
   endtask

   task automatic test_fairness();
      bit ok;
      resp_t got;
      clear_logs();
      set_req(1, 1'b0, 16'h0000, 16'h0000);
      push_exp(3'b010, 16'h0000, 1'b0);
      run_hs(1, 1'b1, ok);
      wait_resp(1, ok);
      set_req(1, 1'b0, 16'h0010, 16'h0000);
      set_req(2, 1'b0, 16'h0020, 16'h0000);
      push_exp(3'b100, 16'h3333, 1'b0);
      push_exp(3'b010, 16'hBEEF, 1'b0);
      push_exp(3'b100, 16'h3333, 1'b0);
      push_exp(3'b010, 16'hBEEF, 1'b0);
      run_hs(4, 1'b0, ok);
      req_valid = 3'b000;
      n_checks++;
      if (ok !== 1'b1) $display("FAIL fair_handshakes: got %0d grants expected 5", hs_obs.size()); else n_pass++;
      wait_resp(5, ok);
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < resp_obs.size()) ? resp_obs[i] : '0;
         n_checks++;
         if ({got.vld, got.rdata, got.err} !== {exp_q[i].vld, exp_q[i].rdata, exp_q[i].err})
            $display("FAIL fair_resp[%0d]: got %b/%h/%b expected %b/%h/%b", i, got.vld, got.rdata, got.err,
                     exp_q[i].vld, exp_q[i].rdata, exp_q[i].err);
         else n_pass++;
      end
   endtask

   task automatic test_bounds();
      bit ok;
      resp_t got;
      clear_logs();
      set_req(0, 1'b0, 16'h0FA0, 16'h0000);
      push_exp(3'b001, 16'h0000, 1'b1);
      run_hs(1, 1'b1, ok);
      wait_resp(1, ok);
      n_checks++;
      if (oe_cnt != 0 || we_obs.size() != 0)
         $display("FAIL bnd_err_no_access: got oe=%0d we=%0d expected 0 0", oe_cnt, we_obs.size());
      else n_pass++;
      set_req(0, 1'b1, 16'h0F9C, 16'h1234);
      push_exp(3'b001, 16'h0000, 1'b0);
      run_hs(1, 1'b1, ok);
      wait_resp(2, ok);
      set_req(0, 1'b0, 16'h0F9F, 16'h0000);
      push_exp(3'b001, 16'h1234, 1'b0);
      run_hs(1, 1'b1, ok);
      wait_resp(3, ok);
      n_checks++;
      if (we_obs.size() != 1 || we_obs[0].addr !== 14'd999 || we_obs[0].data !== 16'h1234)
         $display("FAIL bnd_last_write: got %0d writes addr=%0d data=%h expected 1 at 999 data 1234",
                  we_obs.size(), we_obs[0].addr, we_obs[0].data);
      else n_pass++;
      n_checks++;
      if (oe_cnt != 1) $display("FAIL bnd_oe_count: got %0d expected 1", oe_cnt); else n_pass++;
      for (int i = 0; i < exp_q.size(); i++) begin
         got = (i < resp_obs.size()) ? resp_obs[i] : '0;
         n_checks++;
         if ({got.vld, got.rdata, got.err} !== {exp_q[i].vld, exp_q[i].rdata, exp_q[i].err})
            $display("FAIL bnd_resp[%0d]: got %b/%h/%b expected %b/%h/%b", i, got.vld, got.rdata, got.err,
                     exp_q[i].vld, exp_q[i].rdata, exp_q[i].err);
         else n_pass++;
      end
   endtask

   task automatic test_reset_abort();
      bit ok;
      clear_logs();
      set_req(0, 1'b1, 16'h0030, 16'h5555);
      run_hs(1, 1'b1, ok);
      n_checks++;
      if (mem_we !== 1'b1) $display("FAIL abort_we_before: got %b expected 1", mem_we); else n_pass++;
      #2;
      set_req(0, 1'b0, 16'h0010, 16'h0000);
      set_req(1, 1'b0, 16'h0020, 16'h0000);
      reset_n = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wdata, mem_we, mem_oe} !== 55'd0)
         $display("FAIL abort_async_zero: got rr=%b rv=%b we=%b oe=%b ma=%h expected all 0",
                  req_ready, resp_valid, mem_we, mem_oe, mem_addr);
      else n_pass++;
      repeat (2) @(posedge clock);
      #1 reset_n = 1'b1;
      push_exp(3'b001, 16'hBEEF, 1'b0);
      run_hs(1, 1'b1, ok);
      req_valid = 3'b000;
      n_checks++;
      if (hs_obs[hs_obs.size()-1].gnt !== 3'b001)
         $display("FAIL abort_next_grant: got %b expected 001", hs_obs[hs_obs.size()-1].gnt);
      else n_pass++;
      wait_resp(1, ok);
      repeat (4) @(posedge clock);
      n_checks++;
      if (resp_obs.size() != 1 || {resp_obs[0].vld, resp_obs[0].rdata, resp_obs[0].err} !==
          {exp_q[0].vld, exp_q[0].rdata, exp_q[0].err})
         $display("FAIL abort_responses: got %0d responses (first %b/%h) expected 1 (001/beef)",
                  resp_obs.size(), resp_obs[0].vld, resp_obs[0].rdata);
      else n_pass++;
      n_checks++;
      if (mem[12] !== 16'h0000) $display("FAIL abort_no_write: got %h expected 0000", mem[12]); else n_pass++;
   endtask

   task automatic test_idle();
      bit ok;
      clear_logs();
      req_valid = 3'b000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clock);
         n_checks++;
         if ({req_ready, resp_valid, mem_we, mem_oe} !== 8'd0)
            $display("FAIL idle_cycle[%0d]: got rr=%b rv=%b we=%b oe=%b expected all 0", i, req_ready, resp_valid, mem_we, mem_oe);
         else n_pass++;
      end
      @(posedge clock); #1;
      set_req(2, 1'b0, 16'h0020, 16'h0000);
      push_exp(3'b100, 16'h3333, 1'b0);
      @(negedge clock);
      n_checks++;
      if (req_ready !== 3'b100) $display("FAIL idle_then_grant: got %b expected 100", req_ready); else n_pass++;
      run_hs(1, 1'b1, ok);
      wait_resp(1, ok);
      n_checks++;
      if (ok !== 1'b1 || {resp_obs[0].vld, resp_obs[0].rdata, resp_obs[0].err} !== {exp_q[0].vld, exp_q[0].rdata, exp_q[0].err})
         $display("FAIL idle_resp: got %b/%h/%b expected 100/3333/0", resp_obs[0].vld, resp_obs[0].rdata, resp_obs[0].err);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_rr_order();
      test_write_read();
      test_fairness();
      test_bounds();
      test_reset_abort();
      test_idle();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
